// File: rtl/sparse_sel_scheduler.sv
// Two-level sparse selection scheduler: takes a 16-byte block and its nonzero
// mask, then issues 1-4 beats. Each beat carries group/byte select codes for a
// 16-to-4 mux, so up to four nonzero bytes are gathered per cycle.
module sparse_sel_scheduler #(
    parameter int PERF_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [127:0]      in_data,
    input  logic [15:0]       in_mask,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [127:0]      out_data,
    output logic [3:0]        sel_level0,
    output logic [7:0]        sel_level1,
    output logic [3:0]        out_bvalid,
    output logic [1:0]        out_beat,
    output logic              out_last,
    output logic [PERF_W-1:0] perf_beats
);

    typedef enum logic {S_IDLE, S_ISSUE} state_t;

    // Lowest two set bits of a 4-bit group; unused slots stay index 0 / invalid.
    typedef struct packed {
        logic       v1;
        logic [1:0] i1;
        logic       v0;
        logic [1:0] i0;
    } pick_t;

    function automatic pick_t pick2(input logic [3:0] nib);
        pick_t p;
        p = '0;
        for (int i = 0; i < 4; i++) begin
            if (nib[i]) begin
                if (!p.v0) begin
                    p.v0 = 1'b1;
                    p.i0 = 2'(i);
                end else if (!p.v1) begin
                    p.v1 = 1'b1;
                    p.i1 = 2'(i);
                end
            end
        end
        return p;
    endfunction

    state_t              state_q, state_d;
    logic                valid_q, valid_d;
    logic [127:0]        data_q, data_d;
    logic [15:0]         rem_q, rem_d;
    logic [3:0]          sel0_q, sel0_d;
    logic [7:0]          sel1_q, sel1_d;
    logic [3:0]          bv_q, bv_d;
    logic [1:0]          beat_q, beat_d;
    logic                last_q, last_d;
    logic [PERF_W-1:0]   perf_q, perf_d;

    logic                hs, accept, load;
    logic [15:0]         src;
    logic                found_a, found_b;
    logic [1:0]          ga, gb;
    pick_t               pa, pb;
    logic [15:0]         used;
    logic [3:0]          c_sel0;
    logic [7:0]          c_sel1;
    logic [3:0]          c_bv;
    logic [15:0]         c_rem;

    assign hs       = valid_q && out_ready;
    // A new block may enter while the final beat of the previous one drains.
    assign in_ready = (state_q == S_IDLE) || (hs && last_q);
    assign accept   = in_valid && in_ready;
    // Beat codes come from the fresh mask on accept, otherwise from what is left.
    assign src      = accept ? in_mask : rem_q;

    // Decode one beat from the mask: groups A/B, two bytes from each.
    always_comb begin
        found_a = 1'b0;
        found_b = 1'b0;
        ga      = 2'd0;
        gb      = 2'd0;
        for (int g = 0; g < 4; g++) begin
            if (src[4*g +: 4] != 4'd0) begin
                if (!found_a) begin
                    found_a = 1'b1;
                    ga      = 2'(g);
                end else if (!found_b) begin
                    found_b = 1'b1;
                    gb      = 2'(g);
                end
            end
        end
        pa = pick2(found_a ? src[{ga, 2'b00} +: 4] : 4'd0);
        pb = pick2(found_b ? src[{gb, 2'b00} +: 4] : 4'd0);
        used = '0;
        if (pa.v0) used[{ga, pa.i0}] = 1'b1;
        if (pa.v1) used[{ga, pa.i1}] = 1'b1;
        if (pb.v0) used[{gb, pb.i0}] = 1'b1;
        if (pb.v1) used[{gb, pb.i1}] = 1'b1;
        c_sel0 = {gb, ga};
        c_sel1 = {pb.i1, pb.i0, pa.i1, pa.i0};
        c_bv   = {pb.v1, pb.v0, pa.v1, pa.v0};
        c_rem  = src & ~used;
    end

    // Next-state: accept / advance / retire, plus the saturating beat counter.
    always_comb begin
        state_d = state_q;
        valid_d = valid_q;
        data_d  = data_q;
        rem_d   = rem_q;
        sel0_d  = sel0_q;
        sel1_d  = sel1_q;
        bv_d    = bv_q;
        beat_d  = beat_q;
        last_d  = last_q;
        perf_d  = perf_q;
        load    = 1'b0;

        if (hs && (perf_q != {PERF_W{1'b1}})) perf_d = perf_q + PERF_W'(1);

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d = S_ISSUE;
                    valid_d = 1'b1;
                    data_d  = in_data;
                    beat_d  = 2'd0;
                    load    = 1'b1;
                end
            end
            S_ISSUE: begin
                if (accept) begin
                    // Back-to-back block: its beat 0 follows with no bubble.
                    data_d = in_data;
                    beat_d = 2'd0;
                    load   = 1'b1;
                end else if (hs) begin
                    if (last_q) begin
                        state_d = S_IDLE;
                        valid_d = 1'b0;
                    end else begin
                        beat_d = beat_q + 2'd1;
                        load   = 1'b1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                valid_d = 1'b0;
            end
        endcase

        if (load) begin
            sel0_d = c_sel0;
            sel1_d = c_sel1;
            bv_d   = c_bv;
            rem_d  = c_rem;
            last_d = (c_rem == 16'd0);
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            valid_q <= 1'b0;
            data_q  <= '0;
            rem_q   <= '0;
            sel0_q  <= '0;
            sel1_q  <= '0;
            bv_q    <= '0;
            beat_q  <= '0;
            last_q  <= 1'b0;
            perf_q  <= '0;
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
            data_q  <= data_d;
            rem_q   <= rem_d;
            sel0_q  <= sel0_d;
            sel1_q  <= sel1_d;
            bv_q    <= bv_d;
            beat_q  <= beat_d;
            last_q  <= last_d;
            perf_q  <= perf_d;
        end
    end

    assign out_valid  = valid_q;
    assign out_data   = data_q;
    assign sel_level0 = sel0_q;
    assign sel_level1 = sel1_q;
    assign out_bvalid = bv_q;
    assign out_beat   = beat_q;
    assign out_last   = last_q;
    assign perf_beats = perf_q;

endmodule

// File: tb/tb_sparse_sel_scheduler.sv
// Bench for sparse_sel_scheduler: directed and random blocks checked against a
// mask-walking reference model, with hold checks while the consumer stalls.
module tb_sparse_sel_scheduler;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_data;
    logic [15:0]  in_mask;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_data;
    logic [3:0]   sel_level0;
    logic [7:0]   sel_level1;
    logic [3:0]   out_bvalid;
    logic [1:0]   out_beat;
    logic         out_last;
    logic [31:0]  perf_beats;

    sparse_sel_scheduler #(.PERF_W(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_mask(in_mask),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .sel_level0(sel_level0), .sel_level1(sel_level1), .out_bvalid(out_bvalid),
        .out_beat(out_beat), .out_last(out_last), .perf_beats(perf_beats)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [127:0] data;
        logic [3:0]   sel0;
        logic [7:0]   sel1;
        logic [3:0]   bv;
        logic [1:0]   beat;
        logic         last;
    } beat_t;

    beat_t exp_q[$];
    beat_t got_q[$];
    beat_t prev;
    logic  stalled = 1'b0;
    logic  acc_in_last = 1'b0;
    int    hs_cnt = 0;
    int    acc_cnt = 0;
    int    total = 0;
    int    passed = 0;

    task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
        total = total + 1;
        assert (obs === exp) passed = passed + 1;
        else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    function automatic beat_t snap();
        beat_t b;
        b.data = out_data;
        b.sel0 = sel_level0;
        b.sel1 = sel_level1;
        b.bv   = out_bvalid;
        b.beat = out_beat;
        b.last = out_last;
        return b;
    endfunction

    // Reference: repeatedly take the two lowest nonempty groups, two lowest
    // bytes from each, until the mask is exhausted (at least one beat).
    task automatic model_push(input logic [15:0] m, input logic [127:0] d);
        logic [15:0] r;
        int grps[$];
        int bits[$];
        beat_t b;
        r = m;
        for (int n = 0; n < 8; n++) begin
            grps.delete();
            b = '0;
            b.data = d;
            b.beat = 2'(n);
            for (int g = 0; g < 4; g++)
                if (r[4*g +: 4] != 4'd0) grps.push_back(g);
            for (int k = 0; k < 2 && k < grps.size(); k++) begin
                bits.delete();
                for (int i = 0; i < 4; i++)
                    if (r[4*grps[k] + i]) bits.push_back(i);
                b.sel0[2*k +: 2] = 2'(grps[k]);
                for (int j = 0; j < 2 && j < bits.size(); j++) begin
                    b.bv[2*k + j] = 1'b1;
                    b.sel1[2*(2*k + j) +: 2] = 2'(bits[j]);
                    r[4*grps[k] + bits[j]] = 1'b0;
                end
            end
            b.last = (r == 16'd0);
            exp_q.push_back(b);
            if (r == 16'd0) break;
        end
    endtask

    // One clock: inputs are already set at this negedge; observe, then advance.
    task automatic cycle();
        beat_t s, e;
        #1;
        acc_in_last = 1'b0;
        if (!rst_n) begin
            exp_q.delete();
            hs_cnt  = 0;
            stalled = 1'b0;
        end else begin
            s = snap();
            if (stalled) chk("hold", s, prev);
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) chk("spurious_beat", out_valid, 1'b0);
                else begin
                    e = exp_q.pop_front();
                    chk("beat", s, e);
                    got_q.push_back(s);
                    hs_cnt++;
                end
            end
            stalled = out_valid && !out_ready;
            prev = s;
            if (in_valid && in_ready) begin
                acc_in_last = out_valid && out_ready && out_last;
                model_push(in_mask, in_data);
                acc_cnt++;
            end
        end
        @(negedge clk);
    endtask

    function automatic logic rdy(input int mode);
        return (mode == 0) ? 1'b1 : (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
    endfunction

    task automatic send(input logic [15:0] m, input logic [127:0] d, input int mode);
        int n, a0;
        n = 0;
        a0 = acc_cnt;
        in_valid = 1'b1;
        in_mask  = m;
        in_data  = d;
        while (acc_cnt == a0 && n < 200) begin
            out_ready = rdy(mode);
            cycle();
            n++;
        end
        chk("accept_timeout", 1'(acc_cnt != a0), 1'b1);
        in_valid = 1'b0;
    endtask

    task automatic drain(input int mode);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || out_valid) && n < 400) begin
            out_ready = rdy(mode);
            cycle();
            n++;
        end
        chk("drain_timeout", exp_q.size(), 0);
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    initial begin
        logic [3:0] f_s0 [4];
        logic [7:0] f_s1 [4];
        logic [3:0] t_s0 [3];
        logic [7:0] t_s1 [3];
        logic [3:0] t_bv [3];
        logic [127:0] d1, d2;
        int h0, p0;

        f_s0 = '{4'h4, 4'h4, 4'hE, 4'hE};
        f_s1 = '{8'h44, 8'hEE, 8'h44, 8'hEE};
        t_s0 = '{4'h4, 4'h8, 4'h3};
        t_s1 = '{8'h04, 8'h0E, 8'h00};
        t_bv = '{4'h7, 4'h7, 4'h1};

        rst_n = 1'b0; in_valid = 1'b1; in_mask = 16'hFFFF; in_data = rnd128(); out_ready = 1'b0;
        @(negedge clk);
        cycle();
        cycle();
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_outputs", snap(), '0);
        chk("rst_perf", perf_beats, 0);
        in_valid = 1'b0;
        rst_n = 1'b1;
        cycle();

        // Full mask: four beats pairing groups 0/1 then 2/3.
        got_q.delete();
        send(16'hFFFF, rnd128(), 0);
        drain(0);
        chk("ffff_nbeats", got_q.size(), 4);
        for (int k = 0; k < 4 && k < got_q.size(); k++) begin
            chk("ffff_sel0", got_q[k].sel0, f_s0[k]);
            chk("ffff_sel1", got_q[k].sel1, f_s1[k]);
            chk("ffff_bv", got_q[k].bv, 4'hF);
            chk("ffff_last", got_q[k].last, 1'(k == 3));
        end

        // Two far-apart bytes: lane 0 from group 0, lane 2 from group 3.
        got_q.delete();
        send(16'h8001, rnd128(), 0);
        drain(0);
        chk("8001_nbeats", got_q.size(), 1);
        if (got_q.size() > 0)
            chk("8001_beat", {got_q[0].sel0, got_q[0].sel1, got_q[0].bv, got_q[0].last},
                {4'hC, 8'h30, 4'h5, 1'b1});

        // Empty mask still yields one empty, final beat.
        got_q.delete();
        send(16'h0000, rnd128(), 0);
        drain(0);
        chk("zero_nbeats", got_q.size(), 1);
        if (got_q.size() > 0)
            chk("zero_beat", {got_q[0].sel0, got_q[0].sel1, got_q[0].bv, got_q[0].beat, got_q[0].last},
                {4'h0, 8'h00, 4'h0, 2'd0, 1'b1});

        // Uneven mask 0x111F: three beats, B group moves as groups empty.
        got_q.delete();
        send(16'h111F, rnd128(), 0);
        drain(0);
        chk("111f_nbeats", got_q.size(), 3);
        for (int k = 0; k < 3 && k < got_q.size(); k++)
            chk("111f_beat", {got_q[k].sel0, got_q[k].sel1, got_q[k].bv, got_q[k].last},
                {t_s0[k], t_s1[k], t_bv[k], 1'(k == 2)});

        // Backpressure: random ready, outputs held while stalled.
        h0 = hs_cnt;
        p0 = int'(perf_beats);
        send(16'hFFFF, rnd128(), 1);
        drain(1);
        chk("bp_handshakes", hs_cnt - h0, 4);
        chk("bp_perf", perf_beats, 32'(p0 + 4));

        // Back-to-back single-beat blocks with in_valid held.
        got_q.delete();
        d1 = rnd128();
        d2 = rnd128();
        out_ready = 1'b1;
        in_valid = 1'b1; in_mask = 16'h0001; in_data = d1;
        cycle();
        in_mask = 16'h0010; in_data = d2;
        chk("b2b_first_valid", out_valid, 1'b1);
        cycle();
        chk("b2b_acc_in_last", acc_in_last, 1'b1);
        in_valid = 1'b0;
        chk("b2b_no_bubble", out_valid, 1'b1);
        chk("b2b_data", out_data, d2);
        drain(0);
        chk("b2b_nbeats", got_q.size(), 2);

        // Random blocks with random gaps and random consumer stalls.
        for (int b = 0; b < 40; b++) begin
            logic [15:0] m;
            m = 16'($urandom);
            if ($urandom_range(0, 5) == 0) m = 16'h0;
            send(m, rnd128(), 1);
            for (int k = 0; k < int'($urandom_range(0, 2)); k++) begin
                out_ready = 1'($urandom_range(0, 1));
                cycle();
            end
        end
        drain(1);
        chk("rand_perf", perf_beats, 32'(hs_cnt));

        // Reset while a block is stalled mid-issue: nothing more comes out.
        send(16'hFFFF, rnd128(), 2);
        out_ready = 1'b0;
        cycle();
        cycle();
        rst_n = 1'b0;
        cycle();
        rst_n = 1'b1;
        chk("rmid_out_valid", out_valid, 1'b0);
        chk("rmid_in_ready", in_ready, 1'b1);
        chk("rmid_outputs", snap(), '0);
        chk("rmid_perf", perf_beats, 0);
        out_ready = 1'b1;
        for (int k = 0; k < 5; k++) cycle();
        chk("rmid_quiet", out_valid, 1'b0);

        // Normal operation resumes after reset.
        send(16'h111F, rnd128(), 1);
        drain(1);
        chk("post_rst_perf", perf_beats, 32'(hs_cnt));

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
